fpaddsub_norm_shift_pipe: RTL
=============================

// Module: fpaddsub_norm_shift_pipe
// PURPOSE
//  Pipelined, parametrised normalization left-shifter for the FP add/sub datapath.
//  - Counts leading zeros of the post-add mantissa and clamps the shift so the exponent never goes below 0.
//  - Shifts in two registered stages: coarse shift in multiples of 4, then fine shift of 0..3.
//  - Adjusts the exponent and flags zero/denormal results.
//  - Sits between the significand adder and the rounding stage, with valid/ready flow control.
// PARAMETERS
//  WIDTH    33                      mantissa width incl. guard bits; bit WIDTH-1 is the normalized leading 1
//  EXP_W    8                       exponent width
//  SHIFT_W  $clog2(WIDTH+1) (=6)    shift-amount width
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        input beat valid
//  in_ready   out  1        block can accept a beat this cycle
//  in_mant    in   WIDTH    unnormalized mantissa
//  in_exp     in   EXP_W    biased exponent before normalization
//  out_valid  out  1        result beat valid
//  out_ready  in   1        downstream accepts the result
//  out_mant   out  WIDTH    normalized mantissa, zero-filled from the LSB
//  out_exp    out  EXP_W    in_exp - out_shift
//  out_shift  out  SHIFT_W  applied left-shift amount
//  out_zero   out  1        in_mant was all zero
//  out_denorm out  1        shift was clamped by the exponent, so the result is not normalized
// BEHAVIOUR
//  - Reset: s1/s2 valid = 0; out_valid = 0.
//    - out_mant, out_exp, out_shift, out_zero and out_denorm all reset to 0.
//    - in_ready = 1 in the cycle after reset deasserts.
//  - Reset mid-operation discards every in-flight beat; no output appears for them.
//  - Handshake: a transfer occurs on any cycle with valid && ready, on both the input and the output side.
//    - Stage advance: s2_en = !s2_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en (combinational).
//    - Output fields hold stable while out_valid && !out_ready.
//    - in_ready never depends on in_valid.
//  - Latency: 2 cycles from input acceptance to out_valid when there is no backpressure.
//    - Throughput: 1 beat/cycle; beat order is preserved; no beat is dropped or duplicated.
//  - Stage 1 (registered at the end of the cycle):
//    - lzc = leading zeros of in_mant, range 0..WIDTH (WIDTH when in_mant is zero).
//    - shift = (lzc < in_exp) ? lzc : in_exp, with the comparison done in max(SHIFT_W, EXP_W) bits.
//      Edge case: lzc == in_exp uses shift = in_exp and sets denorm.
//    - denorm = (lzc >= in_exp) && (in_mant != 0).
//    - zero = (in_mant == 0); when zero is set, force shift = 0, exp = 0, mant = 0, denorm = 0.
//    - Register mant << {shift[SHIFT_W-1:2], 2'b00}, together with shift, in_exp, zero and denorm.
//  - Stage 2:
//    - mant << shift[1:0]; zeros enter at the LSBs; bits beyond WIDTH are discarded.
//    - exp = in_exp - shift, which cannot underflow because of the clamp.
//  - in_exp = 0 with a nonzero mantissa gives shift = 0 and denorm = 1.
//  - MSB already set gives shift = 0 and denorm = 0, unless in_exp = 0.
// STRUCTURE
//  - Package fpaddsub_pkg holds:
//    - the clog2 function;
//    - the default FPADD_MANT_W = 33 and FPADD_EXP_W = 8;
//    - a norm_beat_t struct {mant, exp, shift, zero, denorm} used for both stage registers.
//  - Sub-module fpaddsub_lzc #(WIDTH, SHIFT_W): purely combinational leading-zero counter, tree/priority encoder.
//  - The top level holds the two stage registers, the valid/ready logic, the clamp and the two barrel-shift levels.
// TESTING (WIDTH=33, EXP_W=8; out_ready=1 unless stated)
//  1. mant=33'h1_0000_0000, exp=100 -> 2 cycles later mant unchanged, exp=100, shift=0, zero=0, denorm=0.
//  2. mant=33'h0_0000_0001, exp=100 -> mant=33'h1_0000_0000, exp=68, shift=32, denorm=0.
//  3. mant=33'h0_0000_00F0 (lzc=25), exp=10 -> shift=10, mant=33'h0_0003_C000, exp=0, denorm=1.
//  4. mant=0, exp=50 -> mant=0, exp=0, shift=0, zero=1, denorm=0.
//  5. Backpressure:
//     - Stimulus: 5 back-to-back beats with mant=33'h1<<k for k=0..4, exp=200; out_ready low for cycles 3..6.
//     - Required: in_ready falls once 2 beats are buffered; outputs hold stable during the stall.
//     - Required: all 5 beats emerge in order with shift=32..28.
//  6. Reset: assert rst for 1 cycle while 2 beats are in flight -> out_valid=0 the next cycle; no stale beat ever appears.
//     - Also required: a new beat issued immediately after reset emerges correctly 2 cycles later.

Source files
------------

// File: rtl/fpaddsub_pkg.sv
// Shared types and constants for the FP add/sub normalization pipeline.
// norm_beat_t is the payload held in both stage registers of the normalizer.
package fpaddsub_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    localparam int FPADD_MANT_W  = 33;
    localparam int FPADD_EXP_W   = 8;
    localparam int FPADD_SHIFT_W = clog2(FPADD_MANT_W + 1);

    typedef struct packed {
        logic [FPADD_MANT_W-1:0]  mant;
        logic [FPADD_EXP_W-1:0]   exp;
        logic [FPADD_SHIFT_W-1:0] shift;
        logic                     zero;
        logic                     denorm;
    } norm_beat_t;

endpackage

// File: rtl/fpaddsub_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
// Built as a thermometer of "everything at and above this bit is zero", then summed.
module fpaddsub_lzc #(
    parameter int WIDTH   = 33,
    parameter int SHIFT_W = 6
) (
    input  logic [WIDTH-1:0]   mant,
    output logic [SHIFT_W-1:0] count
);

    logic [WIDTH-1:0] clear_above;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prefix
            assign clear_above[gi] = ~|mant[WIDTH-1:gi];
        end
    endgenerate

    // The thermometer has exactly lzc ones at its top, so its population is the count.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + SHIFT_W'(clear_above[i]);
        end
    end

endmodule

// File: rtl/fpaddsub_norm_shift_pipe.sv
// Two-stage normalization left-shifter with exponent clamp and valid/ready flow control.
// Stage 1 counts leading zeros, clamps and applies the coarse (x4) shift; stage 2 does the fine shift.
module fpaddsub_norm_shift_pipe
    import fpaddsub_pkg::*;
#(
    parameter int WIDTH   = FPADD_MANT_W,
    parameter int EXP_W   = FPADD_EXP_W,
    parameter int SHIFT_W = clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_mant,
    input  logic [EXP_W-1:0]   in_exp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_mant,
    output logic [EXP_W-1:0]   out_exp,
    output logic [SHIFT_W-1:0] out_shift,
    output logic               out_zero,
    output logic               out_denorm
);

    localparam int CMP_W = (SHIFT_W > EXP_W) ? SHIFT_W : EXP_W;

    logic               s1_valid_reg;
    logic               s2_valid_reg;
    norm_beat_t         s1_reg;
    norm_beat_t         s1_next;
    norm_beat_t         s2_reg;
    norm_beat_t         s2_next;
    logic               s1_en;
    logic               s2_en;
    logic [SHIFT_W-1:0] lzc;
    logic [CMP_W-1:0]   lzc_cmp;
    logic [CMP_W-1:0]   exp_cmp;
    logic [CMP_W-1:0]   exp_diff;
    logic [SHIFT_W-1:0] clamp_shift;
    logic               lzc_below_exp;
    logic               mant_zero;

    fpaddsub_lzc #(
        .WIDTH   (WIDTH),
        .SHIFT_W (SHIFT_W)
    ) u_lzc (
        .mant  (in_mant),
        .count (lzc)
    );

    assign s2_en    = !s2_valid_reg || out_ready;
    assign s1_en    = !s1_valid_reg || s2_en;
    assign in_ready = s1_en;

    always_comb begin
        lzc_cmp       = CMP_W'(lzc);
        exp_cmp       = CMP_W'(in_exp);
        lzc_below_exp = (lzc_cmp < exp_cmp);
        mant_zero     = (in_mant == '0);
        // When clamped, the shift equals the exponent, which is <= lzc <= WIDTH and so fits.
        clamp_shift   = lzc_below_exp ? lzc : SHIFT_W'(exp_cmp);

        s1_next = '0;
        if (mant_zero) begin
            s1_next.zero = 1'b1;
        end else begin
            s1_next.mant   = in_mant << {clamp_shift[SHIFT_W-1:2], 2'b00};
            s1_next.exp    = in_exp;
            s1_next.shift  = clamp_shift;
            s1_next.denorm = !lzc_below_exp;
        end
    end

    always_comb begin
        exp_diff     = CMP_W'(s1_reg.exp) - CMP_W'(s1_reg.shift);
        s2_next      = s1_reg;
        s2_next.mant = s1_reg.mant << s1_reg.shift[1:0];
        s2_next.exp  = exp_diff[EXP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s1_reg       <= '0;
            s2_reg       <= '0;
        end else begin
            if (s1_en) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_reg <= s1_next;
                end
            end
            // Stage 2 payload only changes on advance, so outputs hold during a stall.
            if (s2_en) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_reg <= s2_next;
                end
            end
        end
    end

    assign out_valid  = s2_valid_reg;
    assign out_mant   = s2_reg.mant;
    assign out_exp    = s2_reg.exp;
    assign out_shift  = s2_reg.shift;
    assign out_zero   = s2_reg.zero;
    assign out_denorm = s2_reg.denorm;

endmodule
